ghash_core: RTL and testbench

GHASH_CORE -- requirements
Module: ghash_core

---
 rtl/ghash_pkg.sv | 16 +
 rtl/gf128_mul_digit.sv | 27 ++
 rtl/ghash_core.sv | 112 +++++++++++
 tb/tb_ghash_core.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ghash_pkg.sv
// Shared constants for the GHASH datapath: field width, reduction constant R,
// controller state encoding and the legal multiplier-digit check.
package ghash_pkg;
   localparam int W = 128;

   // x^128 = x^7 + x^2 + x + 1, written in GCM (reflected) bit order
   localparam logic [0:W-1] R = {8'hE1, 120'h0};

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MULT = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   function automatic bit digit_legal(input int d);
      return d inside {1, 2, 4, 8, 16, 32};
   endfunction
endpackage

// File: rtl/gf128_mul_digit.sv
// One DIGIT-bit step of the right-shift GF(2^128) multiplier; purely combinational,
// consumes x_in[0] first and returns the updated partial product and shifted multiplicand.
module gf128_mul_digit
   import ghash_pkg::*;
#(
   parameter int DIGIT = 8
) (
   input  logic [0:W-1]     z_in,
   input  logic [0:W-1]     v_in,
   input  logic [0:DIGIT-1] x_in,
   output logic [0:W-1]     z_out,
   output logic [0:W-1]     v_out
);
   logic [0:W-1] zv;
   logic [0:W-1] vv;

   always_comb begin
      zv = z_in;
      vv = v_in;
      for (int i = 0; i < DIGIT; i++) begin
         if (x_in[i]) zv = zv ^ vv;
         vv = {1'b0, vv[0:W-2]} ^ (vv[W-1] ? R : '0);
      end
      z_out = zv;
      v_out = vv;
   end
endmodule

// File: rtl/ghash_core.sv
// GHASH accumulator: one block per 128/DIGIT+1 cycles, oReady low while multiplying, no input buffering.
// Define GHASH_TAG_XOR_EN to add the iEkY0 ports and emit the full GCM tag (Y xor EkY0).
module ghash_core
   import ghash_pkg::*;
#(
   parameter int DIGIT = 8
) (
   input  logic         iClk,
   input  logic         iRst,
   input  logic         iInit,
   input  logic [0:127] iHashKey,
   input  logic         iHashKey_valid,
   input  logic [0:127] iBlock,
   input  logic         iBlock_valid,
   input  logic         iLast,
`ifdef GHASH_TAG_XOR_EN
   input  logic [0:127] iEkY0,
   input  logic         iEkY0_valid,
`endif
   output logic         oReady,
   output logic [0:127] oTag,
   output logic         oTag_valid
);
   if (!digit_legal(DIGIT)) begin : g_bad_digit
      $error("ghash_core: DIGIT=%0d is not one of 1,2,4,8,16,32", DIGIT);
   end

   localparam int N  = W / DIGIT;
   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic          last_q;
   logic [0:W-1]  y, h, x, z, v, tag_y;
   logic [0:W-1]  z_nxt, v_nxt;

   gf128_mul_digit #(.DIGIT(DIGIT)) u_step (
      .z_in (z),
      .v_in (v),
      .x_in (x[0:DIGIT-1]),
      .z_out(z_nxt),
      .v_out(v_nxt)
   );

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         last_q <= 1'b0;
         y      <= '0;
         h      <= '0;
         x      <= '0;
         z      <= '0;
         v      <= '0;
         tag_y  <= '0;
      end else if (iInit) begin
         state <= S_IDLE;
         cnt   <= '0;
         y     <= '0;
         tag_y <= '0;
         if (iHashKey_valid) h <= iHashKey;
      end else begin
         case (state)
            S_IDLE: begin
               if (iBlock_valid) begin
                  x      <= y ^ iBlock;
                  z      <= '0;
                  v      <= h;
                  last_q <= iLast;
                  cnt    <= '0;
                  state  <= S_MULT;
               end
            end
            S_MULT: begin
               z   <= z_nxt;
               v   <= v_nxt;
               // next digit of X moves to the low indices the step module reads
               x   <= x << DIGIT;
               cnt <= cnt + 1'b1;
               if (cnt == LAST_STEP) begin
                  y <= z_nxt;
                  if (last_q) begin
                     tag_y <= z_nxt;
                     state <= S_DONE;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign oReady     = (state == S_IDLE);
   assign oTag_valid = (state == S_DONE);

`ifdef GHASH_TAG_XOR_EN
   logic [0:W-1] eky0;

   always_ff @(posedge iClk) begin
      if (iRst) eky0 <= '0;
      else if (iEkY0_valid) eky0 <= iEkY0;
   end

   assign oTag = tag_y ^ eky0;
`else
   assign oTag = tag_y;
`endif
endmodule

// File: tb/tb_ghash_core.sv
// Directed bench for ghash_core: vector table on the DIGIT=8 instance, plus
// hand sequences for abort, same-cycle init/valid, reset mid-multiply and held-valid timing.
module tb_ghash_core;
   localparam int N8  = 16;
   localparam int N1  = 128;
   localparam int N32 = 4;

   localparam logic [0:127] H_ID  = 128'h80000000000000000000000000000000;
   localparam logic [0:127] H_TC2 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
   localparam logic [0:127] C_TC2 = 128'h0388dace60b6a392f328c2b971b2fe78;
   localparam logic [0:127] L_TC2 = 128'h00000000000000000000000000000080;
   localparam logic [0:127] Y_TC2 = 128'h5e2ec746917062882c85b0685353deb7;
   localparam logic [0:127] T_TC2 = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;
   localparam logic [0:127] EK2   = 128'h58e2fccefa7e3061367f1d57a4e7455a;
   localparam logic [0:127] P_A   = 128'h0123456789abcdeffedcba9876543210;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         init = 1'b0;
   logic         hkey_vld = 1'b0;
   logic         last = 1'b0;
   logic [0:127] hkey = '0;
   logic [0:127] block = '0;
   logic         blk_vld [3];
   logic         rdy     [3];
   logic [0:127] tag     [3];
   logic         tag_vld [3];
`ifdef GHASH_TAG_XOR_EN
   logic [0:127] ek = '0;
   logic         ek_vld = 1'b0;
   logic [0:127] ek_model = '0;
`endif

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   ghash_core #(.DIGIT(8)) u_d8 (
      .iClk(clk), .iRst(rst), .iInit(init), .iHashKey(hkey), .iHashKey_valid(hkey_vld),
      .iBlock(block), .iBlock_valid(blk_vld[0]), .iLast(last),
`ifdef GHASH_TAG_XOR_EN
      .iEkY0(ek), .iEkY0_valid(ek_vld),
`endif
      .oReady(rdy[0]), .oTag(tag[0]), .oTag_valid(tag_vld[0])
   );

   ghash_core #(.DIGIT(1)) u_d1 (
      .iClk(clk), .iRst(rst), .iInit(init), .iHashKey(hkey), .iHashKey_valid(hkey_vld),
      .iBlock(block), .iBlock_valid(blk_vld[1]), .iLast(last),
`ifdef GHASH_TAG_XOR_EN
      .iEkY0(ek), .iEkY0_valid(ek_vld),
`endif
      .oReady(rdy[1]), .oTag(tag[1]), .oTag_valid(tag_vld[1])
   );

   ghash_core #(.DIGIT(32)) u_d32 (
      .iClk(clk), .iRst(rst), .iInit(init), .iHashKey(hkey), .iHashKey_valid(hkey_vld),
      .iBlock(block), .iBlock_valid(blk_vld[2]), .iLast(last),
`ifdef GHASH_TAG_XOR_EN
      .iEkY0(ek), .iEkY0_valid(ek_vld),
`endif
      .oReady(rdy[2]), .oTag(tag[2]), .oTag_valid(tag_vld[2])
   );

   typedef struct {
      logic [0:127] h;
      logic         two;
      logic [0:127] b0;
      logic [0:127] b1;
      logic [0:127] ek;
      logic [0:127] y;
   } vec_t;

   vec_t vt [7];

   function automatic logic [0:127] exp_tag(input logic [0:127] y);
`ifdef GHASH_TAG_XOR_EN
      return y ^ ek_model;
`else
      return y;
`endif
   endfunction

   task automatic check(input string nm, input logic [0:127] act, input logic [0:127] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic check_int(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_init(input logic ld, input logic [0:127] h);
      init = 1'b1;
      hkey_vld = ld;
      hkey = h;
      tick();
      init = 1'b0;
      hkey_vld = 1'b0;
   endtask

`ifdef GHASH_TAG_XOR_EN
   task automatic set_ek(input logic [0:127] e);
      ek = e;
      ek_vld = 1'b1;
      tick();
      ek_vld = 1'b0;
      ek_model = e;
   endtask
`endif

   // offers one block to instance k, returns edges from acceptance to ready (or tag_valid if last)
   task automatic send(input int k, input logic [0:127] b, input logic l, output int lat);
      int g;
      g = 0;
      while (!rdy[k] && g < 400) begin
         tick();
         g++;
      end
      if (!rdy[k]) check("send_wait_ready", {127'b0, rdy[k]}, 128'd1);
      block = b;
      last = l;
      blk_vld[k] = 1'b1;
      tick();
      blk_vld[k] = 1'b0;
      last = 1'b0;
      lat = 0;
      if (l) begin
         while (!tag_vld[k] && lat < 400) begin
            tick();
            lat++;
         end
      end else begin
         while (!rdy[k] && lat < 400) begin
            tick();
            lat++;
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, low, tv;
      logic [0:127] cap;
      int nk [3];
      nk[0] = N8;
      nk[1] = N1;
      nk[2] = N32;
      for (int k = 0; k < 3; k++) blk_vld[k] = 1'b0;

      vt[0] = '{h: H_ID,  two: 1'b0, b0: P_A,   b1: '0,    ek: 128'h0, y: P_A};
      vt[1] = '{h: H_TC2, two: 1'b0, b0: C_TC2, b1: '0,    ek: 128'h0, y: Y_TC2};
      vt[2] = '{h: H_TC2, two: 1'b1, b0: C_TC2, b1: L_TC2, ek: EK2,    y: T_TC2};
      vt[3] = '{h: H_TC2, two: 1'b0, b0: 128'h0, b1: '0,   ek: {128{1'b1}}, y: 128'h0};
      vt[4] = '{h: 128'h0, two: 1'b0, b0: C_TC2, b1: '0,   ek: 128'h0, y: 128'h0};
      vt[5] = '{h: H_ID,  two: 1'b1, b0: P_A, b1: 128'hffffffffffffffff0000000000000000,
                ek: 128'h0, y: 128'hfedcba9876543210fedcba9876543210};
      vt[6] = '{h: 128'h40000000000000000000000000000000, two: 1'b0,
                b0: 128'h00000000000000000000000000000001, b1: '0,
                ek: 128'h0, y: 128'he1000000000000000000000000000000};

      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("reset_ready", {127'b0, rdy[0]}, 128'd1);
      check("reset_tag", tag[0], 128'h0);
      check("reset_tag_valid", {127'b0, tag_vld[0]}, 128'd0);

      for (int i = 0; i < 7; i++) begin
         do_init(1'b1, vt[i].h);
`ifdef GHASH_TAG_XOR_EN
         set_ek(vt[i].ek);
`endif
         if (vt[i].two) begin
            send(0, vt[i].b0, 1'b0, lat);
            check_int($sformatf("vec%0d_ready_latency", i), lat, N8);
            send(0, vt[i].b1, 1'b1, lat);
         end else begin
            send(0, vt[i].b0, 1'b1, lat);
         end
         check_int($sformatf("vec%0d_tag_latency", i), lat, N8);
         check($sformatf("vec%0d_tag", i), tag[0], exp_tag(vt[i].y));
      end

      // abort mid-multiply, then rerun with the retained key
      do_init(1'b1, H_TC2);
      block = C_TC2;
      blk_vld[0] = 1'b1;
      tick();
      blk_vld[0] = 1'b0;
      repeat (5) tick();
      check("mid_mult_ready", {127'b0, rdy[0]}, 128'd0);
      do_init(1'b0, 128'hdeadbeefdeadbeefdeadbeefdeadbeef);
      check("abort_ready", {127'b0, rdy[0]}, 128'd1);
      check("abort_tag_valid", {127'b0, tag_vld[0]}, 128'd0);
      send(0, C_TC2, 1'b0, lat);
      send(0, L_TC2, 1'b1, lat);
      check("abort_rerun_tag", tag[0], exp_tag(T_TC2));

      // init and block valid together: block must be dropped
      init = 1'b1;
      block = C_TC2;
      blk_vld[0] = 1'b1;
      tick();
      init = 1'b0;
      blk_vld[0] = 1'b0;
      check("init_wins_ready", {127'b0, rdy[0]}, 128'd1);
      tick();
      check("init_wins_ready_2", {127'b0, rdy[0]}, 128'd1);
      send(0, C_TC2, 1'b1, lat);
      check("init_wins_tag", tag[0], exp_tag(Y_TC2));

      // reset pulsed during multiply
      send(0, C_TC2, 1'b0, lat);
      block = L_TC2;
      blk_vld[0] = 1'b1;
      tick();
      blk_vld[0] = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
`ifdef GHASH_TAG_XOR_EN
      ek_model = '0;
`endif
      check("rst_mid_ready", {127'b0, rdy[0]}, 128'd1);
      check("rst_mid_tag", tag[0], 128'h0);
      check("rst_mid_tag_valid", {127'b0, tag_vld[0]}, 128'd0);
      send(0, C_TC2, 1'b1, lat);
      check("rst_clears_key_tag", tag[0], 128'h0);

      // block held valid through the whole operation, per digit width
      for (int k = 0; k < 3; k++) begin
         do_init(1'b1, H_ID);
         block = P_A;
         last = 1'b1;
         blk_vld[k] = 1'b1;
         check($sformatf("held%0d_ready_before", k), {127'b0, rdy[k]}, 128'd1);
         tick();
         low = 0;
         tv = 0;
         cap = '0;
         while (!rdy[k] && low < 400) begin
            low++;
            if (tag_vld[k]) begin
               tv++;
               cap = tag[k];
            end
            tick();
         end
         blk_vld[k] = 1'b0;
         last = 1'b0;
         check_int($sformatf("held%0d_ready_low_cycles", k), low, nk[k] + 1);
         check_int($sformatf("held%0d_tag_valid_pulses", k), tv, 1);
         check($sformatf("held%0d_tag", k), cap, exp_tag(P_A));
         tick();
         check($sformatf("held%0d_no_reaccept", k), {127'b0, rdy[k]}, 128'd1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
